// File: rtl/karat_mult_core.sv
// ---------------------------------------------------------------------------
// karat_mult_core
//   Unsigned full-precision multiplier with a single output register.
//   The product is formed combinationally by a recursive Karatsuba tree
//   (karat_mult_node) and registered into oO on every rising clock edge.
//
//   Parameters
//     wI    : operand width (2..256, odd widths allowed)
//     wBASE : widths at or below this use a direct multiply
//     wO    : product width, fixed at 2*wI
//
//   Ports
//     iClk : clock, rising edge
//     iRst : synchronous active-high reset, clears oO
//     iX   : unsigned multiplicand, wI bits
//     iY   : unsigned multiplier, wI bits
//     oO   : registered product iX*iY, wO bits, one cycle latency
//
//   There is no handshake: a new operand pair is taken on every edge and its
//   product appears on oO after that same edge.
// ---------------------------------------------------------------------------
module karat_mult_node #(
    parameter int N     = 64,
    parameter int wBASE = 16
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] p
);
    // Below N=4 the (H+1)-bit cross term would be as wide as N itself and the
    // recursion would never shrink, so those widths always multiply directly.
    if (N <= wBASE || N < 4) begin : g_direct
        assign p = (2 * N)'(x) * (2 * N)'(y);
    end else begin : g_split
        localparam int L  = N / 2;
        localparam int H  = N - L;
        localparam int W  = 2 * N + 2;
        localparam int PW = 2 * N;

        logic [H-1:0]     xh, yh;
        logic [L-1:0]     xl, yl;
        logic [H:0]       xs, ys;     // H+1 bits so the half-sum carry is kept
        logic [2*H-1:0]   a;
        logic [2*L-1:0]   b;
        logic [2*H+1:0]   c;
        logic [W-1:0]     a_ext, b_ext, c_ext, mid;

        assign xh = x[N-1:L];
        assign yh = y[N-1:L];
        assign xl = x[L-1:0];
        assign yl = y[L-1:0];

        assign xs = {1'b0, xh} + {{(H + 1 - L){1'b0}}, xl};
        assign ys = {1'b0, yh} + {{(H + 1 - L){1'b0}}, yl};

        karat_mult_node #(.N(H),     .wBASE(wBASE)) u_a (.x(xh), .y(yh), .p(a));
        karat_mult_node #(.N(L),     .wBASE(wBASE)) u_b (.x(xl), .y(yl), .p(b));
        karat_mult_node #(.N(H + 1), .wBASE(wBASE)) u_c (.x(xs), .y(ys), .p(c));

        assign a_ext = {{(W - 2 * H){1'b0}}, a};
        assign b_ext = {{(W - 2 * L){1'b0}}, b};
        assign c_ext = {{(W - 2 * H - 2){1'b0}}, c};

        // C - A - B = Xh*Yl + Xl*Yh, which is never negative, so the
        // subtraction cannot borrow out of W bits.
        assign mid = c_ext - a_ext - b_ext;

        assign p = PW'((a_ext << (2 * L)) + (mid << L) + b_ext);
    end
endmodule

module karat_mult_core #(
    parameter  int wI    = 64,
    parameter  int wBASE = 16,
    localparam int wO    = 2 * wI
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic [wI-1:0] iX,
    input  logic [wI-1:0] iY,
    output logic [wO-1:0] oO
);
    logic [wO-1:0] prod;

    karat_mult_node #(.N(wI), .wBASE(wBASE)) u_root (
        .x (iX),
        .y (iY),
        .p (prod)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oO <= '0;
        end else begin
            oO <= prod;
        end
    end
endmodule

// File: tb/tb_karat_mult_core.sv
module tb_karat_mult_core;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [63:0]  x64 = '0, y64 = '0;
    logic [32:0]  x33 = '0, y33 = '0;
    logic [15:0]  x16 = '0, y16 = '0;
    logic [127:0] o64;
    logic [65:0]  o33;
    logic [31:0]  o16;

    karat_mult_core #(.wI(64)) u_dut64 (.iClk(clk), .iRst(rst), .iX(x64), .iY(y64), .oO(o64));
    karat_mult_core #(.wI(33)) u_dut33 (.iClk(clk), .iRst(rst), .iX(x33), .iY(y33), .oO(o33));
    karat_mult_core #(.wI(16)) u_dut16 (.iClk(clk), .iRst(rst), .iX(x16), .iY(y16), .oO(o16));

    // ---------------- scoreboard ----------------
    logic [127:0] exp64_q[$];
    logic [65:0]  exp33_q[$];
    logic [31:0]  exp16_q[$];
    string        name_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- driver tasks ----------------
    task automatic apply(input string nm, input logic r,
                         input logic [63:0] x, input logic [63:0] y,
                         input logic [127:0] e64, input logic [65:0] e33,
                         input logic [31:0] e16);
        @(negedge clk);
        rst = r;
        x64 = x;        y64 = y;
        x33 = x[32:0];  y33 = y[32:0];
        x16 = x[15:0];  y16 = y[15:0];
        exp64_q.push_back(e64);
        exp33_q.push_back(e33);
        exp16_q.push_back(e16);
        name_q.push_back(nm);
    endtask

    task automatic apply_rand(input string nm, input logic r);
        logic [63:0]  x, y;
        logic [127:0] e64;
        logic [65:0]  e33;
        logic [31:0]  e16;
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: x = '0;
            1: y = '1;
            2: begin x = '1; y = '1; end
            default: ;
        endcase
        if (r) begin
            e64 = '0; e33 = '0; e16 = '0;
        end else begin
            e64 = {64'd0, x} * {64'd0, y};
            e33 = {33'd0, x[32:0]} * {33'd0, y[32:0]};
            e16 = {16'd0, x[15:0]} * {16'd0, y[15:0]};
        end
        apply(nm, r, x, y, e64, e33, e16);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp64_q.size() != 0) begin
                logic [127:0] e64;
                logic [65:0]  e33;
                logic [31:0]  e16;
                string        nm;
                e64 = exp64_q.pop_front();
                e33 = exp33_q.pop_front();
                e16 = exp16_q.pop_front();
                nm  = name_q.pop_front();
                n_checks += 3;
                if (o64 !== e64) begin
                    n_fail++;
                    $display("FAIL %s w64: got %h expected %h", nm, o64, e64);
                end
                if (o33 !== e33) begin
                    n_fail++;
                    $display("FAIL %s w33: got %h expected %h", nm, o33, e33);
                end
                if (o16 !== e16) begin
                    n_fail++;
                    $display("FAIL %s w16: got %h expected %h", nm, o16, e16);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset held with all-ones operands: output must be zero.
        apply("reset_ones", 1'b1, '1, '1, '0, '0, '0);
        apply("reset_ones2", 1'b1, '1, '1, '0, '0, '0);
        // First edge after reset release gives the product directly.
        apply("zero_x", 1'b0, 64'h0, 64'hDEADBEEFCAFEF00D, '0, '0, '0);
        apply("one_x", 1'b0, 64'h1, 64'h123456789ABCDEF0,
              128'h0000000000000000123456789ABCDEF0, 66'h0_9ABC_DEF0, 32'h0000_DEF0);
        apply("all_ones", 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
              128'hFFFFFFFFFFFFFFFE0000000000000001, 66'h3_FFFF_FFFC_0000_0001, 32'hFFFE_0001);
        apply("ones32", 1'b0, 64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF,
              128'h0000000000000000FFFFFFFE00000001, 66'h0_FFFF_FFFE_0000_0001, 32'hFFFE_0001);
        apply("top_bit", 1'b0, 64'h8000000000000000, 64'h2,
              128'h00000000000000010000000000000000, '0, '0);
        apply("small", 1'b0, 64'd12345, 64'd6789,
              128'd83810205, 66'd83810205, 32'd83810205);
        // Mid-stream reset: one zero cycle, then correct again.
        apply("mid_rst", 1'b1, '1, '1, '0, '0, '0);
        apply("after_rst", 1'b0, 64'h3, 64'h5, 128'd15, 66'd15, 32'd15);

        for (int i = 0; i < 3000; i++) begin
            apply_rand((i == 1500) ? "rand_rst" : "rand", (i == 1500));
        end

        // Drain: every pushed expectation must be consumed within a bound.
        for (int i = 0; i < 10 && exp64_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        n_checks++;
        if (exp64_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp64_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
